// File: rtl/axisif_sequencer_pkg.sv
// Shared definitions for the AXI-Stream buffer sequencer: width helper and state encoding.
package axisif_sequencer_pkg;

  // Number of bits needed to hold the value n (8 -> 4, 4 -> 3, 2 -> 2).
  function automatic int clogb2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((n >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

  localparam int ST_IDLE = 0;
  localparam int ST_RUN  = 1;
  localparam int ST_DONE = 2;
  localparam int ST_W    = clogb2(ST_DONE);

  typedef enum logic [ST_W-1:0] {
    S_IDLE = ST_W'(ST_IDLE),
    S_RUN  = ST_W'(ST_RUN),
    S_DONE = ST_W'(ST_DONE)
  } state_t;

endpackage

// File: rtl/axisif_sequencer_seq_counter.sv
// Up-counter that saturates at a terminal value; used for the feed and collect indices.
module seq_counter
  import axisif_sequencer_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] TERMINAL = '1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_val,
  output logic             o_fin
);

  logic [WIDTH-1:0] r_val;

  // Count on enable, hold once the terminal value is reached so a job never wraps.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_val <= '0;
    end else if (i_en && !o_fin) begin
      r_val <= r_val + 1'b1;
    end
  end

  assign o_val = r_val;
  assign o_fin = (r_val == TERMINAL);

endmodule

// File: rtl/axisif_sequencer.sv
// Job sequencer: feeds the input buffer into the engine and stores engine results
// into the output buffer, then pulses done to hand the interface back.
//
// state  | meaning
// IDLE   | waiting for a start pulse; outputs quiet
// RUN    | feeding operands and collecting results concurrently
// DONE   | one-cycle done pulse, then back to IDLE
module axisif_sequencer
  import axisif_sequencer_pkg::*;
#(
  parameter  int DATA_WIDTH    = 32,
  parameter  int IN_DATA_NUM   = 8,
  parameter  int OUT_DATA_NUM  = 4,
  localparam int IN_ADR_WIDTH  = clogb2(IN_DATA_NUM),
  localparam int OUT_ADR_WIDTH = clogb2(OUT_DATA_NUM)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_axisif_start,
  output logic                     o_axisif_done,
  output logic [IN_ADR_WIDTH-1:0]  o_axisif_bufferIn_adr,
  input  logic [DATA_WIDTH-1:0]    i_axisif_bufferIn_data,
  output logic [OUT_ADR_WIDTH-1:0] o_axisif_bufferOut_adr,
  output logic [DATA_WIDTH-1:0]    o_axisif_bufferOut_data,
  output logic                     o_axisif_bufferOut_wr,
  output logic [DATA_WIDTH-1:0]    o_eng_in_data,
  output logic                     o_eng_in_valid,
  output logic                     o_eng_in_last,
  input  logic                     i_eng_in_ready,
  input  logic [DATA_WIDTH-1:0]    i_eng_out_data,
  input  logic                     i_eng_out_valid,
  output logic                     o_eng_out_ready,
  output logic                     o_busy,
  output logic                     o_err_overflow
);

  state_t r_state;
  state_t w_state_nxt;

  logic                     r_in_fed;
  logic                     r_out_full;
  logic                     r_err;
  logic [IN_ADR_WIDTH-1:0]  w_in_cnt;
  logic [OUT_ADR_WIDTH-1:0] w_out_cnt;
  logic                     w_in_fin;
  logic                     w_out_fin;

  logic w_start;
  logic w_run;
  logic w_feed_acc;
  logic w_res_acc;
  logic w_wr;
  logic w_in_fed_nxt;
  logic w_out_full_nxt;

  assign w_start        = (r_state == S_IDLE) && i_axisif_start;
  assign w_run          = (r_state == S_RUN);
  assign w_feed_acc     = w_run && !r_in_fed && i_eng_in_ready;
  assign w_res_acc      = w_run && i_eng_out_valid;
  assign w_wr           = w_res_acc && !r_out_full;
  // Lookahead flags let DONE follow the final accept by exactly one cycle.
  assign w_in_fed_nxt   = r_in_fed || (w_feed_acc && w_in_fin);
  assign w_out_full_nxt = r_out_full || (w_wr && w_out_fin);

  seq_counter #(
    .WIDTH    (IN_ADR_WIDTH),
    .TERMINAL (IN_ADR_WIDTH'(IN_DATA_NUM - 1))
  ) u_in_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (w_start),
    .i_en    (w_feed_acc),
    .o_val   (w_in_cnt),
    .o_fin   (w_in_fin)
  );

  seq_counter #(
    .WIDTH    (OUT_ADR_WIDTH),
    .TERMINAL (OUT_ADR_WIDTH'(OUT_DATA_NUM - 1))
  ) u_out_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (w_start),
    .i_en    (w_wr),
    .o_val   (w_out_cnt),
    .o_fin   (w_out_fin)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Job flags: fed/full track completion, err latches any result beyond the last slot.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_start) begin
      r_in_fed   <= 1'b0;
      r_out_full <= 1'b0;
      r_err      <= 1'b0;
    end else if (w_run) begin
      r_in_fed   <= w_in_fed_nxt;
      r_out_full <= w_out_full_nxt;
      if (w_res_acc && r_out_full) r_err <= 1'b1;
    end
  end

  // Next-state and output decode; all outputs quiet outside their active state.
  always_comb begin
    w_state_nxt             = r_state;
    o_axisif_done           = 1'b0;
    o_axisif_bufferIn_adr   = '0;
    o_axisif_bufferOut_adr  = '0;
    o_axisif_bufferOut_data = '0;
    o_axisif_bufferOut_wr   = 1'b0;
    o_eng_in_data           = '0;
    o_eng_in_valid          = 1'b0;
    o_eng_in_last           = 1'b0;
    o_eng_out_ready         = 1'b0;
    o_busy                  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_axisif_start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        o_busy                = 1'b1;
        o_axisif_bufferIn_adr = w_in_cnt;
        o_eng_in_valid        = !r_in_fed;
        o_eng_in_last         = !r_in_fed && w_in_fin;
        if (!r_in_fed) o_eng_in_data = i_axisif_bufferIn_data;
        o_eng_out_ready       = 1'b1;
        if (w_wr) begin
          o_axisif_bufferOut_wr   = 1'b1;
          o_axisif_bufferOut_adr  = w_out_cnt;
          o_axisif_bufferOut_data = i_eng_out_data;
        end
        if (w_in_fed_nxt && w_out_full_nxt) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_busy        = 1'b1;
        o_axisif_done = 1'b1;
        w_state_nxt   = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_err_overflow = r_err;

endmodule

// File: tb/tb_axisif_sequencer.sv
// Bench for axisif_sequencer: job-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized jobs.
module tb_axisif_sequencer;
  localparam int DW    = 32;
  localparam int IN_N  = 8;
  localparam int OUT_N = 4;
  localparam int IAW   = 4;
  localparam int OAW   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, start, eng_in_ready, eng_out_valid;
  logic [DW-1:0]  bin_data, eng_out_data;
  logic           done, bout_wr, eng_in_valid, eng_in_last, eng_out_ready, busy, err;
  logic [IAW-1:0] bin_adr;
  logic [OAW-1:0] bout_adr;
  logic [DW-1:0]  bout_data, eng_in_data;

  axisif_sequencer #(.DATA_WIDTH(DW), .IN_DATA_NUM(IN_N), .OUT_DATA_NUM(OUT_N)) dut (
    .i_clk                   (clk),
    .i_rst                   (rst),
    .i_axisif_start          (start),
    .o_axisif_done           (done),
    .o_axisif_bufferIn_adr   (bin_adr),
    .i_axisif_bufferIn_data  (bin_data),
    .o_axisif_bufferOut_adr  (bout_adr),
    .o_axisif_bufferOut_data (bout_data),
    .o_axisif_bufferOut_wr   (bout_wr),
    .o_eng_in_data           (eng_in_data),
    .o_eng_in_valid          (eng_in_valid),
    .o_eng_in_last           (eng_in_last),
    .i_eng_in_ready          (eng_in_ready),
    .i_eng_out_data          (eng_out_data),
    .i_eng_out_valid         (eng_out_valid),
    .o_eng_out_ready         (eng_out_ready),
    .o_busy                  (busy),
    .o_err_overflow          (err)
  );

  logic [DW-1:0] buf_in  [IN_N];
  logic [DW-1:0] out_mem [OUT_N];
  logic [DW-1:0] fed_q [$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int n_wr    = 0;
  bit cmp_en  = 1'b0;

  always_comb bin_data = buf_in[bin_adr[2:0]];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Job-level model: phase 0 idle, 1 run, 2 done; counts of words fed and results stored.
  int m_phase = 0;
  int m_in    = 0;
  int m_out   = 0;
  bit m_err   = 1'b0;

  always @(negedge clk) begin
    bit ev, ew;
    ev = (m_phase == 1) && (m_in < IN_N);
    ew = (m_phase == 1) && eng_out_valid && (m_out < OUT_N);
    if (cmp_en) begin
      chk("busy",      busy,          m_phase != 0);
      chk("done",      done,          m_phase == 2);
      chk("in_valid",  eng_in_valid,  ev);
      chk("in_last",   eng_in_last,   ev && (m_in == IN_N - 1));
      chk("in_adr",    bin_adr,       (m_phase == 1) ? ((m_in < IN_N) ? m_in : IN_N - 1) : 0);
      chk("in_data",   eng_in_data,   ev ? buf_in[m_in] : 0);
      chk("out_ready", eng_out_ready, m_phase == 1);
      chk("out_wr",    bout_wr,       ew);
      chk("out_adr",   bout_adr,      ew ? m_out : 0);
      chk("out_data",  bout_data,     ew ? eng_out_data : 0);
      chk("err",       err,           m_err);
    end
    if (rst) begin
      m_phase = 0; m_in = 0; m_out = 0; m_err = 1'b0;
    end else begin
      case (m_phase)
        0: if (start) begin m_phase = 1; m_in = 0; m_out = 0; m_err = 1'b0; end
        1: begin
          if (ev && eng_in_ready) m_in++;
          if (eng_out_valid) begin
            if (m_out < OUT_N) m_out++;
            else m_err = 1'b1;
          end
          if (m_in == IN_N && m_out == OUT_N) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Record what the engine actually receives and what lands in the output buffer.
  always @(negedge clk) begin
    if (eng_in_valid && eng_in_ready && !rst) fed_q.push_back(eng_in_data);
    if (bout_wr && !rst) begin
      out_mem[bout_adr[1:0]] = bout_data;
      n_wr++;
    end
    if (done) n_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // rmode: 0 ready always, 1 ready on odd cycles, 2 random. ov_n < 0 gives random results.
  task automatic run_job(input int rmode, input int ov_lo, input int ov_n,
                         input int rst_at, input int restart_at, output int lat);
    lat = -1;
    fed_q.delete();
    for (int i = 0; i < OUT_N; i++) out_mem[i] = '0;
    n_done = 0;
    n_wr   = 0;
    for (int k = 0; k < 300; k++) begin
      start = (k == 0) || (k == restart_at);
      rst   = (k == rst_at);
      case (rmode)
        0:       eng_in_ready = 1'b1;
        1:       eng_in_ready = (k % 2) == 1;
        default: eng_in_ready = 1'($urandom_range(0, 1));
      endcase
      if (ov_n < 0) begin
        eng_out_valid = 1'($urandom_range(0, 1));
        eng_out_data  = $urandom;
      end else begin
        eng_out_valid = (k >= ov_lo) && (k < ov_lo + ov_n);
        eng_out_data  = eng_out_valid ? 32'hA0 + 32'(k - ov_lo) : '0;
      end
      tick();
      if (k == rst_at) break;
      if (done) begin
        lat = k + 1;
        break;
      end
    end
    start = 0; rst = 0; eng_in_ready = 0; eng_out_valid = 0; eng_out_data = '0;
    tick();
  endtask

  task automatic check_fed(input string nm);
    chk({nm, "_fed_n"}, fed_q.size(), IN_N);
    for (int i = 0; i < fed_q.size() && i < IN_N; i++) chk({nm, "_fed_word"}, fed_q[i], buf_in[i]);
  endtask

  task automatic check_out_seq(input string nm);
    for (int i = 0; i < OUT_N; i++) chk({nm, "_out_mem"}, out_mem[i], 32'hA0 + i);
  endtask

  initial begin
    int lat;
    rst = 1; start = 0; eng_in_ready = 0; eng_out_valid = 0; eng_out_data = '0;
    for (int i = 0; i < IN_N; i++) buf_in[i] = 32'h10 + i;
    tick();
    tick();
    chk("rst_busy",  busy, 0);
    chk("rst_valid", eng_in_valid, 0);
    chk("rst_adr",   bin_adr, 0);
    chk("rst_done",  done, 0);
    chk("rst_err",   err, 0);
    chk("rst_wr",    bout_wr, 0);
    rst = 0;
    cmp_en = 1'b1;
    tick();

    // Ready engine, results after the last feed.
    run_job(0, 9, 4, -1, -1, lat);
    chk("ready_lat", lat, 13);
    check_fed("ready");
    check_out_seq("ready");
    chk("ready_ndone", n_done, 1);
    chk("ready_err", err, 0);

    // Back-pressure on alternate cycles.
    run_job(1, 16, 4, -1, -1, lat);
    chk("bp_lat", lat, 20);
    check_fed("bp");
    check_out_seq("bp");

    // Early results plus one overflow result.
    run_job(0, 4, 5, -1, -1, lat);
    chk("early_lat", lat, 9);
    chk("early_err", err, 1);
    chk("early_nwr", n_wr, 4);
    check_out_seq("early");

    // Last feed and last result in the same cycle; err cleared by the new start.
    run_job(0, 5, 4, -1, -1, lat);
    chk("sim_lat", lat, 9);
    chk("sim_err", err, 0);

    // Start pulse during RUN is ignored.
    run_job(0, 9, 4, -1, 3, lat);
    chk("restart_lat", lat, 13);
    chk("restart_ndone", n_done, 1);

    // Reset mid-job, then a clean job.
    run_job(0, 9, 4, 4, -1, lat);
    chk("rst_mid_ndone", n_done, 0);
    chk("rst_mid_busy", busy, 0);
    run_job(0, 9, 4, -1, -1, lat);
    chk("after_rst_lat", lat, 13);
    check_fed("after_rst");

    // Randomized jobs.
    for (int j = 0; j < 10; j++) begin
      for (int i = 0; i < IN_N; i++) buf_in[i] = $urandom;
      run_job(2, 0, -1, -1, -1, lat);
      chk("rand_finished", lat > 0, 1);
      chk("rand_ndone", n_done, 1);
      check_fed("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
